// File: rtl/mod_dadda_mul_pkg.sv
// Shared types and helpers for the Booth / Dadda mantissa multipliers.
// Holds the sequencer state type, the signed Booth digit type and the digit table.
package mod_dadda_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mul_state_t;

    // Radix-4 Booth digit, range -2..+2
    typedef logic signed [2:0] booth_digit_t;

    // Number of radix-4 digits needed for an unsigned nbit multiplier
    function automatic int ndig_of(input int nbit);
        return (nbit + 2) / 2;
    endfunction

    // Triple is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_t booth_digit(input logic [2:0] trip);
        booth_digit_t d;
        d = 3'b000;
        unique case (trip)
            3'b000, 3'b111: d = 3'b000;
            3'b001, 3'b010: d = 3'b001;
            3'b011:         d = 3'b010;
            3'b100:         d = 3'b110;
            3'b101, 3'b110: d = 3'b111;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Single-row Booth digit selector: maps a bit triple and A to d*A.
// Ports: triple (3b), a (NBIT, unsigned) -> mult (NBIT+2, signed).
module booth_digit_sel
    import mod_dadda_mul_pkg::*;
#(
    parameter int NBIT = 11
) (
    input  logic [2:0]             triple,
    input  logic [NBIT-1:0]        a,
    output logic signed [NBIT+1:0] mult
);

    logic signed [NBIT+1:0] a1;
    logic signed [NBIT+1:0] a2;
    booth_digit_t           d;

    // Zero-extended A and 2A; the extra top bit keeps 2A positive so
    // negation sign-extends correctly even when A's MSB is set.
    assign a1 = {2'b00, a};
    assign a2 = {1'b0, a, 1'b0};
    assign d  = booth_digit(triple);

    always_comb begin
        mult = '0;
        unique case (d)
            3'b001:  mult = a1;
            3'b010:  mult = a2;
            3'b111:  mult = -a1;
            3'b110:  mult = -a2;
            default: mult = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// Sequential radix-4 Booth multiplier: one digit per cycle into a 2*NBIT acc.
// Ports: clk, rst_n, in_valid/in_ready + a_i/b_i, flush, out_valid/out_ready + prod_o, busy.
module booth_seq_mul_ctrl
    import mod_dadda_mul_pkg::*;
#(
    parameter int NBIT = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NBIT-1:0]   a_i,
    input  logic [NBIT-1:0]   b_i,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*NBIT-1:0] prod_o,
    output logic              busy
);

    localparam int NDIG = ndig_of(NBIT);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * NBIT;
    localparam int BW   = 2 * NDIG + 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    mul_state_t             state;
    logic [NBIT-1:0]        a_q;
    logic [NBIT-1:0]        b_q;
    logic [PW-1:0]          acc;
    logic [CW-1:0]          cnt;

    logic [BW-1:0]          b_ext;
    logic [2:0]             triple;
    logic signed [NBIT+1:0] mult;
    logic [PW-1:0]          mult_ext;
    logic [PW-1:0]          addend;
    logic [PW-1:0]          acc_nxt;

    // B with an implicit b[-1]=0 below and zero padding above
    assign b_ext  = {{(BW-NBIT-1){1'b0}}, b_q, 1'b0};
    assign triple = 3'(b_ext >> {cnt, 1'b0});

    booth_digit_sel #(
        .NBIT (NBIT)
    ) u_sel (
        .triple (triple),
        .a      (a_q),
        .mult   (mult)
    );

    // Negative multiples wrap mod 2^PW; the total is exact since A*B < 2^PW
    assign mult_ext = {{(PW-NBIT-2){mult[NBIT+1]}}, mult};
    assign addend   = mult_ext << {cnt, 1'b0};
    assign acc_nxt  = acc + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            prod_o    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= ST_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        prod_o    <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Testbench for booth_seq_mul_ctrl: directed cases plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_booth_seq_mul_ctrl;

    localparam int NBIT = 11;
    localparam int NDIG = (NBIT + 2) / 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NBIT-1:0]   a_i = '0;
    logic [NBIT-1:0]   b_i = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*NBIT-1:0] prod_o;
    logic              busy;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    booth_seq_mul_ctrl #(
        .NBIT (NBIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_o    (prod_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=idle, 1=working (countdown), 2=holding result
    int          m_phase = 0;
    int          m_left  = 0;
    bit          m_ov    = 1'b0;
    logic [63:0] m_pend  = '0;
    logic [63:0] m_prod  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_ov    <= 1'b0;
            m_prod  <= '0;
        end else if (flush) begin
            m_phase <= 0;
            m_ov    <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  <= 64'(a_i) * 64'(b_i);
                    m_left  <= NDIG;
                    m_phase <= 1;
                end
                1: begin
                    if (m_left == 1) begin
                        m_prod  <= m_pend;
                        m_ov    <= 1'b1;
                        m_phase <= 2;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: if (out_ready) begin
                    m_ov    <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("cyc_in_ready", 64'(in_ready), 64'(m_phase == 0));
            chk("cyc_busy", 64'(busy), 64'(m_phase != 0));
            chk("cyc_out_valid", 64'(out_valid), 64'(m_ov));
            chk("cyc_prod", 64'(prod_o), m_prod);
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge
    task automatic run_op(input int a, input int b, input int exp);
        int k;
        a_i      = NBIT'(a);
        b_i      = NBIT'(b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'(NDIG));
        chk("prod_literal", 64'(prod_o), 64'(exp));
        chk("model_literal", m_prod, 64'(exp));
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        logic [2*NBIT-1:0] held;

        a_i       = NBIT'($urandom);
        b_i       = NBIT'($urandom);
        in_valid  = 1'($urandom);
        flush     = 1'($urandom);
        out_ready = 1'($urandom);
        #23;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_prod", 64'(prod_o), 64'd0);

        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        chk_on    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", 64'(in_ready), 64'd1);
            chk("idle_busy", 64'(busy), 64'd0);
        end

        run_op(2047, 2047, 4190209);
        run_op(1536, 2, 3072);
        run_op(1234, 0, 0);
        run_op(0, 2047, 0);

        // Backpressure: result must hold, in_valid pulse must be ignored
        out_ready = 1'b0;
        run_op(5, 1023, 5115);
        held = prod_o;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a_i      = 11'd7;
                b_i      = 11'd9;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_prod", 64'(prod_o), 64'(held));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(in_ready), 64'd1);

        // Flush at cnt=3
        a_i      = 11'd100;
        b_i      = 11'd200;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_prod", 64'(prod_o), 64'd5115);
        repeat (8) begin
            @(negedge clk);
            chk("fl_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(3, 7, 21);

        // Asynchronous reset between edges at cnt=2
        a_i      = 11'd2047;
        b_i      = 11'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_prod", 64'(prod_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(11, 13, 143);

        // Random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 24000; c++) begin
            a_i       = NBIT'($urandom);
            b_i       = NBIT'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
